// File: rtl/shared_data_reg_sched_pkg.sv
// shared_data_pkg: scheduler state encoding and parameter legality check
package shared_data_pkg;
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_SETTLE} sched_state_e;
  function automatic bit params_ok(int n_req, int w, int settle, int cnt_w);
    return n_req >= 2 && n_req <= 16 && w >= 1 && settle >= 0 && settle <= 15 && cnt_w >= 1;
  endfunction
endpackage

// File: rtl/shared_data_reg_sched_if.sv
// shared_data_reg_sched_if: requester bus and shared register outputs
interface shared_data_reg_sched_if #(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  parameter int CNT_W = 8
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] wdata;
  logic [N_REQ-1:0]   gnt;
  logic [W-1:0]       my_data;
  logic               data_valid;
  logic               en;
  logic               busy;
  logic [CNT_W-1:0]   wr_count;
  modport master(output req, wdata, input gnt, my_data, data_valid, en, busy, wr_count);
  modport slave(input req, wdata, output gnt, my_data, data_valid, en, busy, wr_count);
endinterface

// File: rtl/shared_data_reg_sched_rr_pick.sv
// rr_pick: rotating-priority picker, first set request at or above the pointer
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [PW-1:0]    o_winner,
  output logic             o_any
);
  logic [PW-1:0] w_idx;
  // scan downward so the lowest offset from the pointer is the last to win
  always_comb begin
    o_winner = '0;
    w_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_idx = PW'((int'(i_ptr) + i) % N_REQ);
      if (i_req[w_idx]) o_winner = w_idx;
    end
  end
  assign o_any = |i_req;
endmodule

// File: rtl/shared_data_reg_sched.sv
// shared_data_reg_sched: round-robin write scheduler for a shared data register
module shared_data_reg_sched
  import shared_data_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int W      = 4,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input logic clk,
  input logic rst,
  shared_data_reg_sched_if.slave bus
);
  localparam int PW = $clog2(N_REQ);
  if (!params_ok(N_REQ, W, SETTLE, CNT_W)) begin : g_bad_params
    $error("shared_data_reg_sched: illegal parameters");
  end
  sched_state_e     r_state, w_state_nxt;
  logic [N_REQ-1:0] r_gnt;
  logic [PW-1:0]    r_win, r_ptr, w_win;
  logic             w_any, w_commit;
  logic [W-1:0]     r_data;
  logic             r_valid;
  logic [3:0]       r_cnt;
  logic [CNT_W-1:0] r_wr;
  rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .i_req(bus.req), .i_ptr(r_ptr), .o_winner(w_win), .o_any(w_any)
  );
  always_comb begin
    w_state_nxt = r_state;
    w_commit = 1'b0;
    case (r_state)
      S_IDLE:   w_state_nxt = w_any ? S_GRANT : S_IDLE;
      S_GRANT: begin
        w_commit = bus.req[r_win];
        w_state_nxt = (w_commit && SETTLE != 0) ? S_SETTLE : S_IDLE;
      end
      S_SETTLE: w_state_nxt = (r_cnt <= 4'd1) ? S_IDLE : S_SETTLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt <= '0;
      r_win <= '0;
      r_ptr <= '0;
      r_data <= '0;
      r_valid <= 1'b0;
      r_cnt <= '0;
      r_wr <= '0;
    end else begin
      r_gnt <= (r_state == S_IDLE && w_any) ? N_REQ'(1) << w_win : '0;
      if (r_state == S_IDLE) r_win <= w_win;
      r_cnt <= w_commit ? 4'(SETTLE) : (r_cnt != 4'd0 ? r_cnt - 4'd1 : r_cnt);
      if (w_commit) begin
        r_data <= bus.wdata[int'(r_win)*W +: W];
        r_valid <= 1'b1;
        r_wr <= &r_wr ? r_wr : r_wr + CNT_W'(1);
        r_ptr <= PW'((int'(r_win) + 1) % N_REQ);
      end
    end
  end
  assign bus.gnt = r_gnt;
  assign bus.my_data = r_data;
  assign bus.data_valid = r_valid;
  assign bus.en = r_valid & r_data[0];
  assign bus.busy = r_state != S_IDLE;
  assign bus.wr_count = r_wr;
endmodule
